mem_access_stage: RTL
=====================

Name: mem_access_stage

Overview:
- MEM stage of the 5-stage pipeline. It sits between the EX/MEM pipeline register and the MEM/WB register.
- Takes the instruction held in EX/MEM and performs one word load/store on a variable-latency data memory using a req/ready handshake.
- Stalls upstream stages while the access is outstanding.
- Presents registered results (memtoReg, regWrite, ALUResult, readData, writeReg, PC) plus a valid strobe to the MEM/WB register.
- Misaligned addresses and memory timeouts squash the register write and raise one-cycle error pulses.

Parameters:
- TIMEOUT, 16: max cycles mem_req is held without mem_ready before the access is aborted (must be ≥1).
- CNT_W, 5: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- valid_in  in  1  EX/MEM holds a live instruction
- memRead_in  in  1  load
- memWrite_in  in  1  store
- memtoReg_in  in  2  WB mux select, passed through
- regWrite_in  in  1  register-file write enable, passed through
- ALUResult_in  in  32  effective address / ALU result
- writeData_in  in  32  store data (rt)
- writeReg_in  in  5  destination register
- PC_in  in  32  instruction PC, passed through
- stall  out  1  combinational; upstream must hold EX/MEM contents while 1
- mem_req  out  1  memory request, registered
- mem_we  out  1  1 = store, registered
- mem_addr  out  32  word address (byte address, [1:0]=0), registered
- mem_wdata  out  32  store data, registered
- mem_rdata  in  32  load data, valid when mem_ready=1
- mem_ready  in  1  access complete this cycle
- valid_out  out  1  one-cycle strobe: outputs below are new
- memtoReg_out  out  2
- regWrite_out  out  1
- ALUResult_out  out  32
- readData_out  out  32
- writeReg_out  out  5
- PC_out  out  32
- err_misalign  out  1  one-cycle pulse
- err_timeout  out  1  one-cycle pulse

Behaviour:
- Interface: one clock, clk. rst is synchronous and active-high.
- Reset: state=IDLE, wait counter=0. Every output register is 0: mem_req, mem_we, mem_addr, mem_wdata, valid_out, all *_out, and both err pulses. Reset has priority over all other conditions.
- Reset mid-access: mem_req falls at that edge. No valid_out or error pulse is produced. The in-flight instruction is discarded.
- mem_op = valid_in & (memRead_in | memWrite_in).
- aligned = (ALUResult_in[1:0] == 0).
- If memRead_in and memWrite_in are both set, treat the access as a store.
- FSM states: IDLE, ACCESS.
- IDLE, valid_in=0: valid_out=0, no state change.
- IDLE, valid_in & ~mem_op (ALU op):
  - Next edge: copy pass-through fields, readData_out=0, valid_out=1.
  - Latency 1 cycle. stall=0.
- IDLE, mem_op & ~aligned:
  - Next edge: valid_out=1, regWrite_out=0, readData_out=0, err_misalign=1. Other fields are passed through.
  - No memory request. stall=0.
- IDLE, mem_op & aligned:
  - stall=1 this cycle.
  - Next edge: latch pass-through fields, mem_req=1, mem_we=memWrite_in, mem_addr=ALUResult_in, mem_wdata=writeData_in. Counter=0, goto ACCESS.
  - valid_out=0.
- ACCESS:
  - mem_req, mem_we, mem_addr and mem_wdata stay stable until the cycle mem_ready is sampled.
  - Counter increments each cycle mem_ready=0.
  - stall = ~mem_ready & (counter != TIMEOUT-1).
- ACCESS, mem_ready=1:
  - Next edge: mem_req=0, valid_out=1. readData_out = mem_rdata for a load, 0 for a store. Goto IDLE.
  - Because stall=0 in this cycle, upstream advances on the same edge.
- ACCESS, mem_ready=0 & counter==TIMEOUT-1:
  - Next edge: mem_req=0, valid_out=1, regWrite_out=0, readData_out=0, err_timeout=1. Goto IDLE.
  - A mem_ready arriving after the abort is ignored.
- Latency (aligned memory op):
  - Accepted in cycle N; mem_req high from N+1.
  - If mem_ready=1 in cycle N+k (k≥1), valid_out=1 in N+k+1.
- Zero-wait memory (ready in the first ACCESS cycle): 2-cycle op, back-to-back instructions sustained.
- valid_out, err_misalign and err_timeout are never high for more than one cycle per instruction.
- *_out fields hold their last value while valid_out=0.
- The MEM/WB register is loaded every cycle. regWrite_out must therefore read 0 on cycles where valid_out=0, which makes bubbles harmless.

Test Plan:
- Reset: assert rst for 2 cycles mid-ACCESS -> mem_req=0, valid_out=0, all outputs 0 after the edge; the next ALU op completes normally.
- ALU op: valid_in=1, regWrite=1, ALUResult=0x0000_0010, writeReg=5 -> next cycle valid_out=1, ALUResult_out=0x10, writeReg_out=5, readData_out=0, stall never 1.
- Load, 3-cycle memory: memRead, addr 0x100, mem_ready 3 cycles after mem_req with rdata 0xDEADBEEF -> stall high 3 cycles, mem_addr=0x100, mem_we=0, then readData_out=0xDEADBEEF with valid_out=1.
- Store, zero-wait: memWrite, addr 0x200, data 0x12345678 -> mem_we=1, mem_wdata=0x12345678 for 1 cycle, valid_out one cycle later, readData_out=0; a back-to-back load issues mem_req on the following cycle.
- Misaligned load at 0x102 -> no mem_req, err_misalign pulse, regWrite_out=0, stall=0.
- Timeout with TIMEOUT=4 and mem_ready held 0 -> mem_req high exactly 4 cycles, then err_timeout=1, regWrite_out=0, FSM back in IDLE; a late mem_ready is ignored.

Source files
------------

// File: rtl/mem_access_stage.sv
// mem_access_stage: pipeline MEM stage driving one word load/store on a
// variable-latency req/ready data memory, with misalign and timeout squash.
module mem_access_stage #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic        memRead_in,
    input  logic        memWrite_in,
    input  logic [1:0]  memtoReg_in,
    input  logic        regWrite_in,
    input  logic [31:0] ALUResult_in,
    input  logic [31:0] writeData_in,
    input  logic [4:0]  writeReg_in,
    input  logic [31:0] PC_in,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        valid_out,
    output logic [1:0]  memtoReg_out,
    output logic        regWrite_out,
    output logic [31:0] ALUResult_out,
    output logic [31:0] readData_out,
    output logic [4:0]  writeReg_out,
    output logic [31:0] PC_out,
    output logic        err_misalign,
    output logic        err_timeout
);
    typedef enum logic {IDLE, ACCESS} state_t;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);
    state_t state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic mem_op, aligned, accept, direct, misal, done, tmo;
    // Instruction held across the access so *_out stay stable until completion
    logic [1:0]  p_memtoReg;
    logic        p_regWrite, p_store;
    logic [31:0] p_alu, p_pc;
    logic [4:0]  p_writeReg;

    always_comb begin
        mem_op   = valid_in & (memRead_in | memWrite_in);
        aligned  = ALUResult_in[1:0] == 2'b00;
        accept   = (state == IDLE) & mem_op & aligned;
        direct   = (state == IDLE) & valid_in & ~(mem_op & aligned);
        misal    = (state == IDLE) & mem_op & ~aligned;
        done     = (state == ACCESS) & mem_ready;
        tmo      = (state == ACCESS) & ~mem_ready & (cnt == LAST);
        stall    = (state == IDLE) ? accept : ~mem_ready & (cnt != LAST);
        state_nx = accept ? ACCESS : (done | tmo) ? IDLE : state;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt           <= '0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            valid_out     <= 1'b0;
            memtoReg_out  <= '0;
            regWrite_out  <= 1'b0;
            ALUResult_out <= '0;
            readData_out  <= '0;
            writeReg_out  <= '0;
            PC_out        <= '0;
            err_misalign  <= 1'b0;
            err_timeout   <= 1'b0;
            p_memtoReg    <= '0;
            p_regWrite    <= 1'b0;
            p_store       <= 1'b0;
            p_alu         <= '0;
            p_pc          <= '0;
            p_writeReg    <= '0;
        end else begin
            valid_out    <= direct | done | tmo;
            err_misalign <= misal;
            err_timeout  <= tmo;
            // Bubbles must never write the register file downstream
            regWrite_out <= direct ? regWrite_in & ~misal : done & p_regWrite;
            if (accept) begin
                mem_req    <= 1'b1;
                mem_we     <= memWrite_in;
                mem_addr   <= ALUResult_in;
                mem_wdata  <= writeData_in;
                cnt        <= '0;
                p_memtoReg <= memtoReg_in;
                p_regWrite <= regWrite_in;
                p_store    <= memWrite_in;
                p_alu      <= ALUResult_in;
                p_pc       <= PC_in;
                p_writeReg <= writeReg_in;
            end
            if (state == ACCESS && !mem_ready) cnt <= cnt + 1'b1;
            if (direct) begin
                memtoReg_out  <= memtoReg_in;
                ALUResult_out <= ALUResult_in;
                writeReg_out  <= writeReg_in;
                PC_out        <= PC_in;
                readData_out  <= '0;
            end
            if (done | tmo) begin
                mem_req       <= 1'b0;
                memtoReg_out  <= p_memtoReg;
                ALUResult_out <= p_alu;
                writeReg_out  <= p_writeReg;
                PC_out        <= p_pc;
                readData_out  <= (done & ~p_store) ? mem_rdata : '0;
            end
        end
    end
endmodule
